relu_maxpool_stream: RTL and testbench
======================================

RELU_MAXPOOL_STREAM -- requirements
Module: relu_maxpool_stream

Interface
REQ-001 Parameter NUM_FILTERS, default 16: number of feature maps per frame.
REQ-002 Parameter MAP_SIZE, default 11: feature-map side length in pixels; legal range 2..64.
REQ-003 Parameter DATA_WIDTH, default 32: pixel width, signed two's complement.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 in_valid  input  1  upstream convolution pixel valid.
REQ-007 in_ready  output  1  block accepts in_data this cycle.
REQ-008 in_data  input  DATA_WIDTH  conv output pixel; raster order (row-major) within a map, maps in filter order 0..NUM_FILTERS-1.
REQ-009 out_valid  output  1  pooled pixel available.
REQ-010 out_ready  input  1  downstream accepts out_data.
REQ-011 out_data  output  DATA_WIDTH  ReLU'd 2x2 max-pooled pixel.
REQ-012 out_last  output  1  qualifies out_data as the final pooled pixel of the frame (last map, last pooled position).

Function
REQ-013 Input transfer occurs when in_valid && in_ready; output transfer when out_valid && out_ready.
REQ-014 P = MAP_SIZE/2 (floor); each map yields P*P pooled outputs, raster order; each frame yields NUM_FILTERS*P*P outputs.
REQ-015 Counters col (0..MAP_SIZE-1), row (0..MAP_SIZE-1), map (0..NUM_FILTERS-1) advance only on input transfer; col wraps to 0 and increments row; row wraps to 0 and increments map; map wraps to 0 after NUM_FILTERS-1.
REQ-016 Pixels with row >= 2P or col >= 2P (odd MAP_SIZE trailing row/column) are accepted and discarded; no output, no state change other than counters.
REQ-017 Even row, even col: hold pixel in pair register; even row, odd col: store signed max(pair, pixel) into line buffer entry col/2 (P entries, DATA_WIDTH each).
REQ-018 Odd row, even col: pair register = signed max(linebuf[col/2], pixel); odd row, odd col: result = signed max(pair, pixel), ReLU applied (negative -> 0), loaded into output register.
REQ-019 Comparisons are signed on full DATA_WIDTH; ties keep either operand (value identical); no saturation or width change.
REQ-020 Latency: out_valid asserts the cycle after the input transfer of the 4th pixel of a window (odd row, odd col).
REQ-021 Output register is a single entry; out_data, out_last stable while out_valid && !out_ready.
REQ-022 in_ready = !out_valid || out_ready (combinational); a completing pixel and an output drain in the same cycle are both performed, output register reloaded without a bubble.
REQ-023 Non-completing pixels are also gated by in_ready (simple backpressure; no skid).
REQ-024 out_last asserts with the output produced at map=NUM_FILTERS-1, row=2P-1, col=2P-1; counters then continue, and any discarded trailing pixels of that map still must be consumed before the next frame.
REQ-025 in_valid low or stalled cycles hold all state; no timeout.

Reset
REQ-026 While rst is high: out_valid=0, out_last=0, out_data=0, counters=0, pair register=0; line buffer contents need not be cleared (always written before read).
REQ-027 Reset asserted mid-frame discards the partial frame and any pending output; first transfer after release is treated as map 0, row 0, col 0.
REQ-028 in_ready is 1 during and immediately after reset.

Verification
REQ-029 MAP_SIZE=4, NUM_FILTERS=1, pixels 1..16 raster, out_ready=1 -> outputs 6, 8, 14, 16; out_last only with 16.
REQ-030 MAP_SIZE=4, all pixels -5 except pixel (1,1)=-1 -> all four outputs 0 (ReLU).
REQ-031 MAP_SIZE=5, NUM_FILTERS=2, pixels 0..24 per map -> per map outputs 6, 8, 16, 18; row 4 and col 4 produce nothing; out_last with second map's 18; 8 outputs total.
REQ-032 Backpressure: hold out_ready=0 after first output -> out_valid stays 1, out_data unchanged, in_ready=0, no input consumed; release -> stream resumes, no loss or duplication.
REQ-033 Signed: window {0x7FFFFFFF, 0x80000000, 1, -1} -> out_data 0x7FFFFFFF.
REQ-034 Assert rst after 7 pixels of a MAP_SIZE=4 frame, release, send a full frame 1..16 -> outputs exactly 6, 8, 14, 16.

Source files
------------

// File: rtl/relu_maxpool_stream.sv
// relu_maxpool_stream: streaming ReLU + 2x2/stride-2 max-pool over
// conv-output feature maps arriving in raster order, map after map.
//
// Ports:
//   clk, rst                 clock, async active-high reset
//   in_valid/in_ready/in_data   upstream pixel stream (valid/ready)
//   out_valid/out_ready/out_data/out_last
//                            pooled pixel stream; out_last marks the final
//                            pooled pixel of a frame
// in_ready is combinational: !out_valid || out_ready.
module relu_maxpool_stream #(
  parameter int unsigned NUM_FILTERS = 16,
  parameter int unsigned MAP_SIZE    = 11,
  parameter int unsigned DATA_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last
);

  localparam int unsigned P         = MAP_SIZE / 2;
  localparam int unsigned CW        = $clog2(MAP_SIZE);
  localparam int unsigned MW        = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1;
  localparam int unsigned IW        = (P > 1) ? $clog2(P) : 1;
  localparam bit          HAS_TRAIL = (MAP_SIZE % 2) == 1;

  localparam logic [CW-1:0] COL_MAX   = CW'(MAP_SIZE - 1);
  localparam logic [CW-1:0] LAST_POOL = CW'(2 * P - 1);
  localparam logic [MW-1:0] MAP_MAX   = MW'(NUM_FILTERS - 1);

  logic [CW-1:0]         col;
  logic [CW-1:0]         row;
  logic [MW-1:0]         map;
  logic [DATA_WIDTH-1:0] pair;
  logic [DATA_WIDTH-1:0] linebuf [P];

  logic          xfer_c;
  logic          in_pool_c;
  logic          is_last_c;
  logic [IW-1:0] lb_idx_c;

  function automatic logic [DATA_WIDTH-1:0] smax(input logic [DATA_WIDTH-1:0] a,
                                                 input logic [DATA_WIDTH-1:0] b);
    return ($signed(a) > $signed(b)) ? a : b;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] relu(input logic [DATA_WIDTH-1:0] a);
    return a[DATA_WIDTH-1] ? '0 : a;
  endfunction

  assign in_ready = !out_valid || out_ready;

  // Decode of the current pixel position within the map.
  always_comb begin
    xfer_c    = in_valid && in_ready;
    // Odd map sizes carry one trailing row and column that fall outside every window.
    in_pool_c = !HAS_TRAIL || ((col != COL_MAX) && (row != COL_MAX));
    is_last_c = (map == MAP_MAX) && (row == LAST_POOL) && (col == LAST_POOL);
    lb_idx_c  = IW'(col >> 1);
  end

  // Line buffer keeps the top-row pair maxima; always written before it is read.
  always_ff @(posedge clk) begin
    if (xfer_c && in_pool_c && !row[0] && col[0]) begin
      linebuf[lb_idx_c] <= smax(pair, in_data);
    end
  end

  // Position counters, pair register and the single-entry output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col       <= '0;
      row       <= '0;
      map       <= '0;
      pair      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (xfer_c) begin
        if (col == COL_MAX) begin
          col <= '0;
          if (row == COL_MAX) begin
            row <= '0;
            map <= (map == MAP_MAX) ? '0 : map + MW'(1);
          end else begin
            row <= row + CW'(1);
          end
        end else begin
          col <= col + CW'(1);
        end

        if (in_pool_c) begin
          case ({row[0], col[0]})
            2'b00: pair <= in_data;
            2'b10: pair <= smax(linebuf[lb_idx_c], in_data);
            2'b11: begin
              // Window complete; overrides the drain above so there is no bubble.
              out_data  <= relu(smax(pair, in_data));
              out_last  <= is_last_c;
              out_valid <= 1'b1;
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_relu_maxpool_stream.sv
// Bench for relu_maxpool_stream: two instances (4x4x1 and 5x5x2 maps) share
// the stimulus bus selected by 'sel'; a negedge monitor scores every output
// transfer against an expected queue.
module tb_relu_maxpool_stream;

  logic        clk;
  logic        rst;
  logic        sel;
  logic        in_valid;
  logic [31:0] in_data;
  logic        out_ready;

  logic        in_valid_a, in_ready_a, out_valid_a, out_last_a;
  logic [31:0] out_data_a;
  logic        in_valid_b, in_ready_b, out_valid_b, out_last_b;
  logic [31:0] out_data_b;

  logic        in_ready, out_valid, out_last;
  logic [31:0] out_data;

  assign in_valid_a = in_valid && !sel;
  assign in_valid_b = in_valid && sel;
  assign in_ready   = sel ? in_ready_b  : in_ready_a;
  assign out_valid  = sel ? out_valid_b : out_valid_a;
  assign out_data   = sel ? out_data_b  : out_data_a;
  assign out_last   = sel ? out_last_b  : out_last_a;

  relu_maxpool_stream #(.NUM_FILTERS(1), .MAP_SIZE(4), .DATA_WIDTH(32)) dut_a (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_a), .in_ready(in_ready_a), .in_data(in_data),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
    .out_last(out_last_a)
  );

  relu_maxpool_stream #(.NUM_FILTERS(2), .MAP_SIZE(5), .DATA_WIDTH(32)) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
    .out_last(out_last_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } exp_t;

  typedef struct packed {
    logic [31:0] p00;
    logic [31:0] p01;
    logic [31:0] p10;
    logic [31:0] p11;
    logic [31:0] exp;
  } vec_t;

  exp_t        exp_q[$];
  logic [31:0] px[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          sent_cnt;
  int          rdy_mode = 0;   // 0: always ready, 1: random, 2: held low
  logic        drv_done;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Downstream ready generator.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(99) < 60);
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Output monitor: handshake rule, hold-stability and scoreboard.
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data;
  logic        prev_last;
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      chk("in_ready_rule", 32'(in_ready), 32'(!out_valid || out_ready));
      if (prev_stall) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_data", out_data, prev_data);
        chk("hold_last", 32'(out_last), 32'(prev_last));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("extra_output", out_data, 32'hDEAD_BEEF);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("out_data", out_data, e.data);
          chk("out_last", 32'(out_last), 32'(e.last));
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end
  end

  // Sends px[0..n-1]; in_valid asserted with probability vpct percent.
  task automatic send_stream(input int n, input int vpct);
    int guard = 0;
    sent_cnt = 0;
    while (sent_cnt < n) begin
      @(posedge clk);
      #1;
      in_valid = ($urandom_range(99) < vpct);
      in_data  = px[sent_cnt];
      @(negedge clk);
      if (in_valid && in_ready) sent_cnt++;
      guard++;
      if (guard > 20000) begin
        chk("send_timeout", 32'(sent_cnt), 32'(n));
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int guard = 0;
    while (exp_q.size() != 0 && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() != 0) begin
      chk(name, 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic push_exp(input logic [31:0] d, input logic l);
    exp_t e;
    e.data = d;
    e.last = l;
    exp_q.push_back(e);
  endtask

  task automatic push_frame4(input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] c, input logic [31:0] d);
    push_exp(a, 1'b0);
    push_exp(b, 1'b0);
    push_exp(c, 1'b0);
    push_exp(d, 1'b1);
  endtask

  // Reference model: pool each window of the frames held in px.
  task automatic model_push(input int ms, input int nf, input int frames);
    int p = ms / 2;
    for (int f = 0; f < frames; f++)
      for (int m = 0; m < nf; m++)
        for (int pr = 0; pr < p; pr++)
          for (int pc = 0; pc < p; pc++) begin
            int base = (f * nf + m) * ms * ms;
            logic signed [31:0] mx;
            logic signed [31:0] v;
            mx = $signed(px[base + 2 * pr * ms + 2 * pc]);
            for (int k = 1; k < 4; k++) begin
              v = $signed(px[base + (2 * pr + k / 2) * ms + 2 * pc + k % 2]);
              if (v > mx) mx = v;
            end
            if (mx < 0) mx = 0;
            push_exp(32'(mx), (m == nf - 1) && (pr == p - 1) && (pc == p - 1));
          end
  endtask

  vec_t vt[8];

  initial begin
    vt[0] = '{32'd1,        32'd2,        32'd3,        32'd4,        32'd4};
    vt[1] = '{32'h7FFFFFFF, 32'h80000000, 32'd1,        32'hFFFFFFFF, 32'h7FFFFFFF};
    vt[2] = '{32'hFFFFFFFB, 32'hFFFFFFFB, 32'hFFFFFFFB, 32'hFFFFFFFF, 32'd0};
    vt[3] = '{32'hFFFFFFFD, 32'd10,       32'd10,       32'hFFFFFFF9, 32'd10};
    vt[4] = '{32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000, 32'd0};
    vt[5] = '{32'd0,        32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd0};
    vt[6] = '{32'hFFFFFF9C, 32'd50,       32'd49,       32'h7FFFFFFE, 32'h7FFFFFFE};
    vt[7] = '{32'hFFFFFFFF, 32'd1,        32'hFFFFFFFE, 32'd0,        32'd1};

    rst = 1'b1;
    sel = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    drv_done = 1'b0;

    // Reset state of both instances.
    repeat (3) @(negedge clk);
    chk("rst_valid_a", 32'(out_valid_a), 32'd0);
    chk("rst_data_a", out_data_a, 32'd0);
    chk("rst_last_a", 32'(out_last_a), 32'd0);
    chk("rst_ready_a", 32'(in_ready_a), 32'd1);
    chk("rst_valid_b", 32'(out_valid_b), 32'd0);
    chk("rst_ready_b", 32'(in_ready_b), 32'd1);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(in_ready), 32'd1);

    // 4x4 ramp 1..16.
    px.delete();
    for (int i = 1; i <= 16; i++) px.push_back(32'(i));
    push_frame4(32'd6, 32'd8, 32'd14, 32'd16);
    send_stream(16, 100);
    wait_drain("ramp4_drain");

    // All -5 except (1,1) = -1.
    px.delete();
    for (int i = 0; i < 16; i++) px.push_back((i == 5) ? 32'hFFFFFFFF : 32'hFFFFFFFB);
    push_frame4(32'd0, 32'd0, 32'd0, 32'd0);
    send_stream(16, 100);
    wait_drain("relu_drain");

    // Window vector table, each window tiled over a 4x4 map.
    for (int t = 0; t < 8; t++) begin
      px.delete();
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          case ({r[0], c[0]})
            2'b00:   px.push_back(vt[t].p00);
            2'b01:   px.push_back(vt[t].p01);
            2'b10:   px.push_back(vt[t].p10);
            default: px.push_back(vt[t].p11);
          endcase
      push_frame4(vt[t].exp, vt[t].exp, vt[t].exp, vt[t].exp);
      rdy_mode = t % 2;
      send_stream(16, (t % 2 == 1) ? 60 : 100);
      wait_drain("vec_drain");
    end
    rdy_mode = 0;

    // Backpressure: stall after first output, then release.
    px.delete();
    for (int i = 1; i <= 16; i++) px.push_back(32'(i));
    push_frame4(32'd6, 32'd8, 32'd14, 32'd16);
    rdy_mode = 2;
    drv_done = 1'b0;
    fork
      begin
        send_stream(16, 100);
        drv_done = 1'b1;
      end
    join_none
    for (int g = 0; g < 50 && !out_valid; g++) @(negedge clk);
    repeat (5) @(negedge clk);
    chk("bp_valid", 32'(out_valid), 32'd1);
    chk("bp_data", out_data, 32'd6);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_consumed", 32'(sent_cnt), 32'd6);
    rdy_mode = 0;
    for (int g = 0; g < 200 && !drv_done; g++) @(negedge clk);
    chk("bp_driver_done", 32'(drv_done), 32'd1);
    wait_drain("bp_drain");

    // 5x5, two maps, ramp 0..24 per map.
    sel = 1'b1;
    px.delete();
    for (int m = 0; m < 2; m++)
      for (int i = 0; i < 25; i++) px.push_back(32'(i));
    for (int m = 0; m < 2; m++) begin
      push_exp(32'd6, 1'b0);
      push_exp(32'd8, 1'b0);
      push_exp(32'd16, 1'b0);
      push_exp(32'd18, m == 1);
    end
    send_stream(50, 100);
    wait_drain("ramp5_drain");

    // Randomized frames against the reference model.
    rdy_mode = 1;
    for (int it = 0; it < 3; it++) begin
      sel = it[0];
      px.delete();
      for (int i = 0; i < 150; i++)
        px.push_back(($urandom_range(1) == 1) ? 32'($urandom) : 32'($signed($urandom_range(8)) - 4));
      if (sel) begin
        model_push(5, 2, 3);
        send_stream(150, 70);
      end else begin
        model_push(4, 1, 9);
        send_stream(144, 70);
      end
      wait_drain("rand_drain");
    end
    rdy_mode = 0;

    // Mid-frame reset: 7 pixels, reset, then a clean frame.
    sel = 1'b0;
    px.delete();
    for (int i = 1; i <= 16; i++) px.push_back(32'(i));
    push_exp(32'd6, 1'b0);
    send_stream(7, 100);
    wait_drain("partial_drain");
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 rst = 1'b0;
    push_frame4(32'd6, 32'd8, 32'd14, 32'd16);
    send_stream(16, 100);
    wait_drain("after_rst_drain");

    // Reset with an output pending discards it.
    rdy_mode = 2;
    send_stream(6, 100);
    @(negedge clk);
    chk("pend_valid", 32'(out_valid), 32'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("pend_cleared", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    rdy_mode = 0;
    push_frame4(32'd6, 32'd8, 32'd14, 32'd16);
    send_stream(16, 100);
    wait_drain("pend_rst_drain");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
